// File: rtl/clock_mode_pkg.sv
// -----------------------------------------------------------------------------
// clock_mode_pkg
//   Definitions shared by the front-panel mode sequencer and the display mux.
//   - MODE_EDIT   : index of the edit (modify) mode.
//   - mode_state_e: the two states of the mode sequencer.
//   - mode_idx_t  : mode index at the default 4-bit panel width.
// -----------------------------------------------------------------------------
package clock_mode_pkg;

  localparam int MODE_EDIT = 0;

  typedef enum logic {
    ST_USER = 1'b0,
    ST_EDIT = 1'b1
  } mode_state_e;

  // Mode index as seen by the display mux (up to 16 modes).
  typedef logic [3:0] mode_idx_t;

endpackage : clock_mode_pkg

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Turns one raw, asynchronous push-button into clean one-cycle press pulses.
//   2-FF synchroniser -> debounce counter -> rising-edge pulse, plus optional
//   auto-repeat while the button stays held (HOLD_CYCLES = 0 disables it).
//   A button found held when reset releases is ignored until it has been seen
//   released once.
// Ports
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   btn_raw_i  in  raw button level, asynchronous
//   press_o    out registered one-cycle press / repeat pulse
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic [1:0]      valid_q;      // fills with ones once the synchroniser holds real samples
  logic            arm_q;        // set once the button has been seen released
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q;
  logic            rise;
  logic            rpt_fire;

  // Debounce: count cycles where the synchronised level disagrees with the
  // accepted level; flip the accepted level on the DEBOUNCE_CYCLES-th one.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign rise = db_d & ~db_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      valid_q  <= '0;
      arm_q    <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw_i;
      sync2_q  <= sync1_q;
      valid_q  <= {valid_q[0], 1'b1};
      arm_q    <= arm_q | (valid_q[1] & ~sync2_q);
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= arm_q & (rise | rpt_fire);
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_repeat
      localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
      localparam int RPT_W   = $clog2(RPT_MAX + 1);

      logic [RPT_W-1:0] rpt_cnt_q;
      logic             rpt_on_q;   // hold delay elapsed, now repeating
      logic             held;

      // Held and not being released on this edge.
      assign held     = db_q & db_d;
      assign rpt_fire = held & (rpt_on_q ? (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1))
                                         : (rpt_cnt_q == RPT_W'(HOLD_CYCLES - 1)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rpt_cnt_q <= '0;
          rpt_on_q  <= 1'b0;
        end else if (!held) begin
          rpt_cnt_q <= '0;
          rpt_on_q  <= 1'b0;
        end else if (rpt_fire) begin
          rpt_cnt_q <= '0;
          rpt_on_q  <= 1'b1;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
        end
      end
    end else begin : g_no_repeat
      assign rpt_fire = 1'b0;
    end
  endgenerate

  assign press_o = press_q;

endmodule : btn_conditioner

// File: rtl/mode_sequencer.sv
// -----------------------------------------------------------------------------
// mode_sequencer
//   Display-mode selector for the clock front panel. Mode 0 is edit mode,
//   modes 1..NUM_MODES-1 are user modes. Up/down step (with wrap) through the
//   user modes, modify toggles into and out of edit mode (restoring the user
//   mode it left), load_en jumps straight to a legal user mode.
//   Priority within one cycle: modify > load_en > up/down; up+down cancel.
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_up        in   raw up button, asynchronous
//   btn_down      in   raw down button, asynchronous
//   btn_modify    in   raw modify button, asynchronous
//   load_en       in   one-cycle strobe: load load_mode
//   load_mode     in   requested user mode (ignored if out of range)
//   mode          out  current mode index
//   edit_active   out  high while mode is the edit mode
//   mode_changed  out  one-cycle pulse in the cycle after mode changed value
// -----------------------------------------------------------------------------
module mode_sequencer
  import clock_mode_pkg::*;
#(
  parameter int NUM_MODES       = 8,
  parameter int MODE_W          = 4,
  parameter int INIT_MODE       = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_modify,
  input  logic              load_en,
  input  logic [MODE_W-1:0] load_mode,
  output logic [MODE_W-1:0] mode,
  output logic              edit_active,
  output logic              mode_changed
);

  localparam logic [MODE_W-1:0] MODE_ZERO  = MODE_W'(MODE_EDIT);
  localparam logic [MODE_W-1:0] MODE_FIRST = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_INIT  = MODE_W'(INIT_MODE);

  logic up_p, down_p, modify_p;

  mode_state_e       state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [MODE_W-1:0] saved_q, saved_d;
  logic              edit_q;
  logic              changed_q;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_btn_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (btn_up),
    .press_o   (up_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_btn_down (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (btn_down),
    .press_o   (down_p)
  );

  // Modify never auto-repeats: a held centre button must not toggle edit mode.
  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (0),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_btn_modify (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_i (btn_modify),
    .press_o   (modify_p)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    saved_d = saved_q;
    case (state_q)
      ST_USER: begin
        if (modify_p) begin
          saved_d = mode_q;
          mode_d  = MODE_ZERO;
          state_d = ST_EDIT;
        end else if (load_en) begin
          // An out-of-range load is dropped along with any same-cycle step.
          if ((load_mode >= MODE_FIRST) && (load_mode <= MODE_LAST)) begin
            mode_d = load_mode;
          end
        end else if (up_p && !down_p) begin
          mode_d = (mode_q == MODE_LAST) ? MODE_FIRST : mode_q + MODE_W'(1);
        end else if (down_p && !up_p) begin
          mode_d = (mode_q == MODE_FIRST) ? MODE_LAST : mode_q - MODE_W'(1);
        end
      end
      ST_EDIT: begin
        // Up/down/load belong to the edit-field datapath while editing.
        if (modify_p) begin
          mode_d  = saved_q;
          state_d = ST_USER;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_USER;
      mode_q    <= MODE_INIT;
      saved_q   <= MODE_INIT;
      edit_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      saved_q   <= saved_d;
      edit_q    <= (mode_d == MODE_ZERO);
      changed_q <= (mode_d != mode_q);
    end
  end

  assign mode         = mode_q;
  assign edit_active  = edit_q;
  assign mode_changed = changed_q;

endmodule : mode_sequencer

// File: tb/tb_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mode_sequencer
//   Directed bench for mode_sequencer. dut uses the default parameters
//   (no auto-repeat); dut_rpt uses HOLD_CYCLES=16, REPEAT_CYCLES=8.
//   Inputs change 1 time unit after a rising edge and outputs are sampled
//   there too, so "edge k" below is the k-th rising edge after a change.
// -----------------------------------------------------------------------------
module tb_mode_sequencer;
  import clock_mode_pkg::*;

  localparam int UP = 0;
  localparam int DN = 1;
  localparam int MD = 2;

  logic      clk = 1'b0;
  logic      rst_n;
  logic [2:0] btn;
  logic      load_en;
  mode_idx_t load_mode;
  mode_idx_t mode;
  logic      edit_active;
  logic      mode_changed;

  logic      up2;
  mode_idx_t mode2;
  logic      edit2;
  logic      chg2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mode_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btn[UP]),
    .btn_down     (btn[DN]),
    .btn_modify   (btn[MD]),
    .load_en      (load_en),
    .load_mode    (load_mode),
    .mode         (mode),
    .edit_active  (edit_active),
    .mode_changed (mode_changed)
  );

  mode_sequencer #(
    .HOLD_CYCLES   (16),
    .REPEAT_CYCLES (8)
  ) dut_rpt (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (up2),
    .btn_down     (1'b0),
    .btn_modify   (1'b0),
    .load_en      (1'b0),
    .load_mode    (4'd0),
    .mode         (mode2),
    .edit_active  (edit2),
    .mode_changed (chg2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Press one button and check the update lands on exactly the 7th edge.
  task automatic step_chk(input int b, input logic [3:0] from_m, input logic [3:0] to_m,
                          input string tag);
    btn[b] = 1'b1;
    repeat (6) tick();
    chk({tag, "_early"}, 8'(mode), 8'(from_m));
    tick();
    chk({tag, "_land"}, 8'(mode), 8'(to_m));
    chk({tag, "_chg"}, 8'(mode_changed), 8'd1);
    tick();
    chk({tag, "_chg_end"}, 8'(mode_changed), 8'd0);
    btn[b] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (8) tick();
    btn[b] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic ld(input logic [3:0] v);
    load_en   = 1'b1;
    load_mode = v;
    tick();
    load_en   = 1'b0;
    load_mode = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    btn       = '0;
    load_en   = 1'b0;
    load_mode = '0;
    up2       = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_mode", 8'(mode), 8'd1);
    chk("rst_edit", 8'(edit_active), 8'd0);
    chk("rst_chg", 8'(mode_changed), 8'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_mode", 8'(mode), 8'd1);

    // 1. Wrap and latency
    step_chk(UP, 4'd1, 4'd2, "up1");
    step_chk(UP, 4'd2, 4'd3, "up2");
    step_chk(UP, 4'd3, 4'd4, "up3");
    step_chk(UP, 4'd4, 4'd5, "up4");
    step_chk(UP, 4'd5, 4'd6, "up5");
    step_chk(UP, 4'd6, 4'd7, "up6");
    step_chk(UP, 4'd7, 4'd1, "up_wrap");
    step_chk(DN, 4'd1, 4'd7, "dn_wrap");

    // 2. Bounce: 3-cycle glitch ignored, 4-cycle press accepted once
    btn[UP] = 1'b1;
    repeat (3) tick();
    btn[UP] = 1'b0;
    repeat (10) tick();
    chk("glitch_mode", 8'(mode), 8'd7);
    btn[UP] = 1'b1;
    repeat (4) tick();
    btn[UP] = 1'b0;
    repeat (10) tick();
    chk("stable4_mode", 8'(mode), 8'd1);

    // 3. Edit mode
    ld(4'd5);
    chk("ld5_mode", 8'(mode), 8'd5);
    press(MD);
    chk("edit_mode", 8'(mode), 8'd0);
    chk("edit_flag", 8'(edit_active), 8'd1);
    press(UP);
    chk("edit_up", 8'(mode), 8'd0);
    press(DN);
    chk("edit_dn", 8'(mode), 8'd0);
    ld(4'd3);
    chk("edit_ld", 8'(mode), 8'd0);
    chk("edit_ld_chg", 8'(mode_changed), 8'd0);
    press(MD);
    chk("exit_mode", 8'(mode), 8'd5);
    chk("exit_flag", 8'(edit_active), 8'd0);

    // 4. Priority and load
    ld(4'd2);
    chk("ld2_mode", 8'(mode), 8'd2);
    btn[UP] = 1'b1;
    btn[DN] = 1'b1;
    repeat (8) tick();
    btn[UP] = 1'b0;
    btn[DN] = 1'b0;
    repeat (8) tick();
    chk("updn_cancel", 8'(mode), 8'd2);
    ld(4'd6);
    chk("ld6_mode", 8'(mode), 8'd6);
    chk("ld6_chg", 8'(mode_changed), 8'd1);
    tick();
    chk("ld6_chg_end", 8'(mode_changed), 8'd0);
    ld(4'd6);
    chk("ld_same_chg", 8'(mode_changed), 8'd0);
    ld(4'd0);
    chk("ld0_mode", 8'(mode), 8'd6);
    chk("ld0_chg", 8'(mode_changed), 8'd0);
    ld(4'd9);
    chk("ld9_mode", 8'(mode), 8'd6);
    chk("ld9_chg", 8'(mode_changed), 8'd0);
    btn[MD] = 1'b1;
    repeat (6) tick();
    load_en   = 1'b1;
    load_mode = 4'd3;
    tick();
    load_en   = 1'b0;
    load_mode = '0;
    chk("md_vs_ld_mode", 8'(mode), 8'd0);
    chk("md_vs_ld_edit", 8'(edit_active), 8'd1);
    tick();
    btn[MD] = 1'b0;
    repeat (8) tick();
    press(MD);
    chk("md_vs_ld_exit", 8'(mode), 8'd6);

    // 6. Reset mid-press while in edit
    press(MD);
    chk("pre_rst_edit", 8'(mode), 8'd0);
    btn[UP] = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_mode", 8'(mode), 8'd1);
    chk("async_rst_edit", 8'(edit_active), 8'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("held_after_rst", 8'(mode), 8'd1);
    btn[UP] = 1'b0;
    repeat (10) tick();
    chk("release_after_rst", 8'(mode), 8'd1);
    press(UP);
    chk("repress_after_rst", 8'(mode), 8'd2);

    // 5. Auto-repeat: db high on edges 6..45, steps land on edges 7,23,31,39
    chk("rpt_start", 8'(mode2), 8'd1);
    up2 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      int exp_m;
      tick();
      exp_m = 1 + int'(k >= 7) + int'(k >= 23) + int'(k >= 31) + int'(k >= 39);
      chk($sformatf("rpt_e%0d", k), 8'(mode2), 8'(exp_m));
      if (k == 40) up2 = 1'b0;
    end
    repeat (10) tick();
    chk("rpt_final", 8'(mode2), 8'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mode_sequencer
